uart_rx_mmio: RTL and testbench

Memory-mapped UART receiver. It is the inbound counterpart of the CPU-side UART write path in the memory subsystem. It deserializes 8N1 frames from the serial rx pin and buffers the bytes in a small FIFO. The CPU reads them through the physical address and read-enable produced by the MMU decode, and the block exposes the Rfull flag to the memory wrapper.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 61 ++++++
 rtl/uart_rx_mmio.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_mmio.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: register offsets, STATUS bit layout, receiver
// state encoding and the data width used by both receive and transmit sides.
package uart_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] REG_DATA   = 2'b00;
  localparam logic [1:0] REG_STATUS = 2'b01;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAME_ERR = 3;
  localparam int STAT_CNT_LSB   = 4;
  localparam int STAT_CNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO. A pop is honoured only when non-empty; a push when full
// lands only if a pop frees a slot in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [DATA_W-1:0]       wdata_i,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: synchronizer, bit-timing FSM, receive FIFO
// and a DATA/STATUS read port with sticky overrun and framing-error flags.
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] address,
  input  logic        re,
  output logic [31:0] r_data,
  output logic        Rfull,
  output logic        rx_irq
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  logic              rx_meta_q, rx_s_q, rx_s_d_q;
  rx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic              push, ferr_set, ovr_set, pop_req, clr_req;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [1:0]        reg_sel;
  logic              unused_addr;

  assign reg_sel     = address[3:2];
  assign unused_addr = ^{address[15:4], address[1:0]};

  // Flops preset to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_s_d_q  <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_s_d_q  <= rx_s_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_s_d_q && !rx_s_q) begin
          state_d = ST_START;
          baud_d  = '0;
        end
      end
      ST_START: begin
        if (baud_q == BAUD_HALF) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d         = '0;
          shift_d[bit_q] = rx_s_q;
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    push     = 1'b0;
    ferr_set = 1'b0;
    if (state_q == ST_STOP && baud_q == BAUD_LAST) begin
      push     = rx_s_q;
      ferr_set = !rx_s_q;
    end
  end

  assign pop_req = re && (reg_sel == REG_DATA);
  assign clr_req = re && (reg_sel == REG_STATUS);
  assign ovr_set = push && fifo_full && !pop_req;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop_req),
    .wdata_i (shift_q),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A set in the same cycle as a STATUS read wins over the clear.
  assign overrun_d   = ovr_set  | (overrun_q   & ~clr_req);
  assign frame_err_d = ferr_set | (frame_err_q & ~clr_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign Rfull  = fifo_full;
  assign rx_irq = !fifo_empty;

  always_comb begin
    r_data = '0;
    case (reg_sel)
      REG_DATA: begin
        if (!fifo_empty) r_data = {{(32-DATA_W){1'b0}}, fifo_rdata};
      end
      REG_STATUS: begin
        r_data[STAT_NOT_EMPTY]                    = !fifo_empty;
        r_data[STAT_FULL]                         = fifo_full;
        r_data[STAT_OVERRUN]                      = overrun_q;
        r_data[STAT_FRAME_ERR]                    = frame_err_q;
        r_data[STAT_CNT_LSB +: STAT_CNT_W]        = STAT_CNT_W'(fifo_count);
      end
      default: r_data = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio: frames are bit-banged on rx at negedges and
// registers are observed combinationally with re low, then popped/cleared.
module tb_uart_rx_mmio;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam logic [1:0] SEL_DATA   = 2'b00;
  localparam logic [1:0] SEL_STATUS = 2'b01;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [15:0] address;
  logic        re;
  logic [31:0] r_data;
  logic        Rfull;
  logic        rx_irq;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  uart_rx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .address (address),
    .re      (re),
    .r_data  (r_data),
    .Rfull   (Rfull),
    .rx_irq  (rx_irq)
  );

  task automatic driveBit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Start bit, eight data bits LSB first, then the given stop level.
  task automatic sendFrame(input logic [7:0] data, input logic stopBit);
    @(negedge clk);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
    driveBit(stopBit);
  endtask

  task automatic peek(input logic [1:0] sel, output logic [31:0] val);
    address = {12'h000, sel, 2'b00};
    re = 1'b0;
    #1;
    val = r_data;
  endtask

  task automatic pulseRe(input logic [1:0] sel);
    address = {12'h000, sel, 2'b00};
    re = 1'b1;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; rx = 1'b1; re = 1'b0; address = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      peek(2'(s), v);
      checkCount++;
      if (v !== 32'h0) $display("[TB] FAIL reset_rdata sel=%0d: got %h expected %h", s, v, 32'h0);
      else passCount++;
    end
    checkCount++;
    if (Rfull !== 1'b0) $display("[TB] FAIL reset_rfull: got %b expected 0", Rfull);
    else passCount++;
    checkCount++;
    if (rx_irq !== 1'b0) $display("[TB] FAIL reset_irq: got %b expected 0", rx_irq);
    else passCount++;
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [31:0] v;
    sendFrame(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    peek(SEL_STATUS, v);
    checkCount++;
    if (v !== 32'h11) $display("[TB] FAIL single_status: got %h expected %h", v, 32'h11);
    else passCount++;
    checkCount++;
    if (rx_irq !== 1'b1) $display("[TB] FAIL single_irq: got %b expected 1", rx_irq);
    else passCount++;
    peek(SEL_DATA, v);
    checkCount++;
    if (v !== 32'hA5) $display("[TB] FAIL single_data: got %h expected %h", v, 32'hA5);
    else passCount++;
    pulseRe(SEL_DATA);
    peek(SEL_STATUS, v);
    checkCount++;
    if (v !== 32'h0) $display("[TB] FAIL single_status_after_pop: got %h expected %h", v, 32'h0);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [31:0] expv;
    for (int i = 1; i <= 4; i++) sendFrame(8'(i), 1'b1);
    peek(SEL_STATUS, v);
    checkCount++;
    if (v !== 32'h43) $display("[TB] FAIL b2b_status_full: got %h expected %h", v, 32'h43);
    else passCount++;
    checkCount++;
    if (Rfull !== 1'b1) $display("[TB] FAIL b2b_rfull: got %b expected 1", Rfull);
    else passCount++;
    sendFrame(8'h05, 1'b1);
    repeat (4) @(negedge clk);
    peek(SEL_STATUS, v);
    checkCount++;
    if (v !== 32'h47) $display("[TB] FAIL b2b_status_overrun: got %h expected %h", v, 32'h47);
    else passCount++;
    for (int i = 0; i < 5; i++) begin
      expv = (i < 4) ? 32'(i + 1) : 32'h0;
      peek(SEL_DATA, v);
      checkCount++;
      if (v !== expv) $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, v, expv);
      else passCount++;
      pulseRe(SEL_DATA);
    end
    peek(SEL_STATUS, v);
    checkCount++;
    if (v !== 32'h04) $display("[TB] FAIL b2b_status_drained: got %h expected %h", v, 32'h04);
    else passCount++;
    pulseRe(SEL_STATUS);
    peek(SEL_STATUS, v);
    checkCount++;
    if (v !== 32'h0) $display("[TB] FAIL b2b_status_cleared: got %h expected %h", v, 32'h0);
    else passCount++;
  endtask

  task automatic test_frame_error();
    logic [31:0] v;
    sendFrame(8'h3C, 1'b0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    peek(SEL_STATUS, v);
    checkCount++;
    if (v !== 32'h08) $display("[TB] FAIL ferr_status: got %h expected %h", v, 32'h08);
    else passCount++;
    pulseRe(SEL_STATUS);
    peek(SEL_STATUS, v);
    checkCount++;
    if (v !== 32'h0) $display("[TB] FAIL ferr_cleared: got %h expected %h", v, 32'h0);
    else passCount++;
    sendFrame(8'h7E, 1'b1);
    repeat (4) @(negedge clk);
    peek(SEL_STATUS, v);
    checkCount++;
    if (v !== 32'h11) $display("[TB] FAIL ferr_next_status: got %h expected %h", v, 32'h11);
    else passCount++;
    peek(SEL_DATA, v);
    checkCount++;
    if (v !== 32'h7E) $display("[TB] FAIL ferr_next_data: got %h expected %h", v, 32'h7E);
    else passCount++;
    pulseRe(SEL_DATA);
  endtask

  task automatic test_glitch();
    logic [31:0] v;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    peek(SEL_STATUS, v);
    checkCount++;
    if (v !== 32'h0) $display("[TB] FAIL glitch_status: got %h expected %h", v, 32'h0);
    else passCount++;
    sendFrame(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    peek(SEL_DATA, v);
    checkCount++;
    if (v !== 32'h5A) $display("[TB] FAIL glitch_next_data: got %h expected %h", v, 32'h5A);
    else passCount++;
    pulseRe(SEL_DATA);
  endtask

  // The stop-bit push lands on the posedge just after the 154th negedge
  // following the start-bit negedge; the DATA read is placed on that edge.
  task automatic test_coincident_pop();
    logic [31:0] v;
    logic [7:0] fill [4];
    logic [7:0] expq [4];
    fill = '{8'h11, 8'h22, 8'h33, 8'h44};
    expq = '{8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) sendFrame(fill[i], 1'b1);
    peek(SEL_STATUS, v);
    checkCount++;
    if (v !== 32'h43) $display("[TB] FAIL coinc_prefull: got %h expected %h", v, 32'h43);
    else passCount++;
    fork
      sendFrame(8'h55, 1'b1);
      begin
        @(negedge clk);
        repeat (154) @(negedge clk);
        address = {12'h000, SEL_DATA, 2'b00};
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    peek(SEL_STATUS, v);
    checkCount++;
    if (v !== 32'h43) $display("[TB] FAIL coinc_status: got %h expected %h", v, 32'h43);
    else passCount++;
    for (int i = 0; i < 4; i++) begin
      peek(SEL_DATA, v);
      checkCount++;
      if (v !== {24'h0, expq[i]}) $display("[TB] FAIL coinc_data[%0d]: got %h expected %h", i, v, {24'h0, expq[i]});
      else passCount++;
      pulseRe(SEL_DATA);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    logic [7:0] partial;
    partial = 8'h81;
    sendFrame(8'h99, 1'b1);
    repeat (4) @(negedge clk);
    peek(SEL_STATUS, v);
    checkCount++;
    if (v !== 32'h11) $display("[TB] FAIL rstmid_pre_status: got %h expected %h", v, 32'h11);
    else passCount++;
    @(negedge clk);
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(partial[i]);
    rx = partial[4];
    repeat (8) @(negedge clk);
    reset = 1'b1;
    peek(SEL_STATUS, v);
    checkCount++;
    if (v !== 32'h0) $display("[TB] FAIL rstmid_status: got %h expected %h", v, 32'h0);
    else passCount++;
    peek(SEL_DATA, v);
    checkCount++;
    if (v !== 32'h0) $display("[TB] FAIL rstmid_data: got %h expected %h", v, 32'h0);
    else passCount++;
    checkCount++;
    if ({Rfull, rx_irq} !== 2'b00) $display("[TB] FAIL rstmid_flags: got %b expected 00", {Rfull, rx_irq});
    else passCount++;
    @(negedge clk);
    rx = 1'b1;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    peek(SEL_STATUS, v);
    checkCount++;
    if (v !== 32'h0) $display("[TB] FAIL rstmid_idle_status: got %h expected %h", v, 32'h0);
    else passCount++;
    sendFrame(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    peek(SEL_STATUS, v);
    checkCount++;
    if (v !== 32'h11) $display("[TB] FAIL rstmid_next_status: got %h expected %h", v, 32'h11);
    else passCount++;
    peek(SEL_DATA, v);
    checkCount++;
    if (v !== 32'h81) $display("[TB] FAIL rstmid_next_data: got %h expected %h", v, 32'h81);
    else passCount++;
    pulseRe(SEL_DATA);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_coincident_pop();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
